// File: rtl/des_sbox_seq.sv
// Iterative DES S-box stage: evaluates S1..S8 over STEPS cycles,
// SBOX_PER_CYCLE boxes per cycle, and hands the 32-bit result to the
// P permutation through a valid/ready handshake.
module des_sbox_seq #(
  parameter int SBOX_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] data_out,
  output logic        busy
);

  localparam int STEPS = 8 / SBOX_PER_CYCLE;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int LOG_P = $clog2(SBOX_PER_CYCLE);

  generate
    if (!(SBOX_PER_CYCLE == 1 || SBOX_PER_CYCLE == 2 ||
          SBOX_PER_CYCLE == 4 || SBOX_PER_CYCLE == 8)) begin : g_bad_cfg
      $error("des_sbox_seq: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
    end
  endgenerate

  // FIPS 46-3 tables, entry 4*(box-1)+row; leftmost hex digit is column 0.
  localparam logic [15:0][3:0] SBOX_ROWS [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  // six = {b1,b2,b3,b4,b5,b6}; row = {b1,b6}, col = {b2..b5}.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
    logic [4:0] row_sel;
    logic [3:0] col;
    row_sel = {box, six[5], six[0]};
    col     = six[4:1];
    return SBOX_ROWS[row_sel][~col];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [47:0]      din_q;     // remaining input groups, next box at [47:42]
  logic [47:0]      din_load;  // data_in reordered so DES bit 1 is the MSB
  logic [31:0]      acc_q;     // nibbles shift in from the right, S1 ends on top
  logic [31:0]      acc_step;
  logic [31:0]      dout_q;
  logic             last_step;
  logic             unused_bit;

  // data_in[0] carries no DES bit.
  assign unused_bit = data_in[0];
  assign last_step  = (cnt_q == CNT_W'(STEPS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Input reorder and one step worth of S-box lookups.
  always_comb begin
    logic [31:0] nibs;
    logic [5:0]  six;
    logic [2:0]  box_idx;
    din_load = '0;
    nibs     = '0;
    six      = '0;
    box_idx  = '0;
    for (int k = 1; k <= 48; k++) din_load[48-k] = data_in[k];
    for (int i = 0; i < SBOX_PER_CYCLE; i++) begin
      six     = 6'(din_q >> (42 - 6 * i));
      box_idx = (3'(cnt_q) << LOG_P) + 3'(i);
      nibs    = (nibs << 4) | {28'd0, sbox_lookup(box_idx, six)};
    end
    acc_step = (acc_q << (4 * SBOX_PER_CYCLE)) | nibs;
  end

  // Counter, accumulator and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      dout_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          cnt_q <= '0;
          acc_q <= '0;
        end
        BUSY: begin
          acc_q <= acc_step;
          cnt_q <= last_step ? '0 : cnt_q + CNT_W'(1);
          if (last_step) dout_q <= acc_step;
        end
        default: ;
      endcase
    end
  end

  // Input word: captured on accept, consumed SBOX_PER_CYCLE groups per step.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) din_q <= din_load;
    else if (state_q == BUSY)        din_q <= din_q << (6 * SBOX_PER_CYCLE);
  end

  // Result back into DES bit numbering; bit 0 stays 0.
  always_comb begin
    data_out = '0;
    for (int k = 1; k <= 32; k++) data_out[k] = dout_q[32-k];
  end

endmodule
